// File: rtl/if_fetch_unit.sv
// ============================================================================
//  if_fetch_unit -- MangoMIPS32 instruction-fetch front end: PC generation,
//  single-outstanding ibus reads, instruction FIFO and redirect handling.
//  Optional IF_ADEL_EN: misaligned redirect yields an address-error entry.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_ack,
  input  logic [31:0] ibus_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
`ifdef IF_ADEL_EN
  output logic        inst_adel,
`endif
  input  logic        id_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DISCARD = 2'd1,
    IDLE    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       saved_pc_q, saved_pc_d;
  logic              saved_bad_q, saved_bad_d;

  logic [31:0]       mem_inst [BUF_DEPTH];
  logic [31:0]       mem_pc   [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_idx;
  logic [CNT_W-1:0]  count_q, count_d, cnt_base;

  logic              ack_hit, pop, flush, push;
  logic [31:0]       push_inst, push_pc;
  logic [31:0]       redir_pc;
  logic              redir_bad;

`ifdef IF_ADEL_EN
  logic              mem_adel [BUF_DEPTH];
  logic              push_adel;
  assign redir_pc  = redirect_pc;
  assign redir_bad = |redirect_pc[1:0];
  assign inst_adel = mem_adel[rd_ptr];
`else
  assign redir_pc  = redirect_pc & ~32'h3;
  assign redir_bad = 1'b0;
`endif

  assign ibus_req   = req_q;
  assign ibus_addr  = pc_q;
  assign inst       = mem_inst[rd_ptr];
  assign inst_pc    = mem_pc[rd_ptr];
  assign inst_valid = (count_q != '0);

  assign ack_hit  = req_q & ibus_ack;
  assign pop      = inst_valid & id_ready;
  assign cnt_base = count_q - CNT_W'(pop);

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    pc_d        = pc_q;
    saved_pc_d  = saved_pc_q;
    saved_bad_d = saved_bad_q;
    flush       = 1'b0;
    push        = 1'b0;
    push_inst   = ibus_rdata;
    push_pc     = pc_q;
`ifdef IF_ADEL_EN
    push_adel   = 1'b0;
`endif
    if (redirect) begin
      flush = 1'b1;
      if (req_q && !ibus_ack) begin
        // Bus cannot be abandoned mid-request: wait out the stale response.
        state_d     = DISCARD;
        saved_pc_d  = redir_pc;
        saved_bad_d = redir_bad;
      end else if (redir_bad) begin
        state_d   = IDLE;
        req_d     = 1'b0;
        push      = 1'b1;
        push_inst = 32'h0;
        push_pc   = redir_pc;
`ifdef IF_ADEL_EN
        push_adel = 1'b1;
`endif
      end else begin
        state_d = RUN;
        req_d   = 1'b1;
        pc_d    = redir_pc;
      end
    end else begin
      case (state_q)
        DISCARD: begin
          if (ack_hit) begin
            if (saved_bad_q) begin
              state_d   = IDLE;
              req_d     = 1'b0;
              push      = 1'b1;
              push_inst = 32'h0;
              push_pc   = saved_pc_q;
`ifdef IF_ADEL_EN
              push_adel = 1'b1;
`endif
            end else begin
              state_d = RUN;
              req_d   = 1'b1;
              pc_d    = saved_pc_q;
            end
          end
        end
        RUN: begin
          if (ack_hit) begin
            push  = 1'b1;
            pc_d  = pc_q + 32'd4;
            req_d = (cnt_base + CNT_W'(1)) < DEPTH_C;
          end else if (!req_q) begin
            req_d = cnt_base < DEPTH_C;
          end
        end
        default: req_d = 1'b0;
      endcase
    end
    count_d = (flush ? '0 : cnt_base) + CNT_W'(push);
  end

  assign wr_idx = flush ? '0 : wr_ptr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= RUN;
      req_q       <= 1'b0;
      pc_q        <= RESET_PC;
      saved_pc_q  <= RESET_PC;
      saved_bad_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      pc_q        <= pc_d;
      saved_pc_q  <= saved_pc_d;
      saved_bad_q <= saved_bad_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_inst[i] <= 32'h0;
        mem_pc[i]   <= 32'h0;
`ifdef IF_ADEL_EN
        mem_adel[i] <= 1'b0;
`endif
      end
    end else begin
      count_q <= count_d;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= push ? PTR_W'(1) : '0;
      end else begin
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (push) begin
        mem_inst[wr_idx] <= push_inst;
        mem_pc[wr_idx]   <= push_pc;
`ifdef IF_ADEL_EN
        mem_adel[wr_idx] <= push_adel;
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: directed bus/redirect scenarios,
// expected words queued at ack time and checked when decode consumes them.
`default_nettype none

module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_ack = 1'b0;
  logic [31:0] ibus_rdata = 32'h0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        id_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
`ifdef IF_ADEL_EN
  logic        inst_adel;
`endif

  if_fetch_unit dut (
    .clk        (clk),
    .resetn     (resetn),
    .ibus_req   (ibus_req),
    .ibus_addr  (ibus_addr),
    .ibus_ack   (ibus_ack),
    .ibus_rdata (ibus_rdata),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
`ifdef IF_ADEL_EN
    .inst_adel  (inst_adel),
`endif
    .id_ready   (id_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] sb[$];
  logic [63:0] mon_exp;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Consumption monitor: every word decode accepts must be the next expected.
  always @(negedge clk) begin
    if (resetn && inst_valid && id_ready && !redirect) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got inst=%h pc=%h, expected no output", inst, inst_pc);
      end else begin
        mon_exp = sb.pop_front();
        if ({inst, inst_pc} !== mon_exp) begin
          n_fail++;
          $display("FAIL sb_word: got inst=%h pc=%h, expected inst=%h pc=%h",
                   inst, inst_pc, mon_exp[63:32], mon_exp[31:0]);
        end
      end
    end
  end

  task automatic idle();
    ibus_ack = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic ack_cycle(input logic [31:0] addr);
    chk("ack_req", 32'(ibus_req), 32'd1);
    chk("ack_addr", ibus_addr, addr);
    ibus_ack   = 1'b1;
    ibus_rdata = data_of(addr);
    sb.push_back({data_of(addr), addr});
    @(posedge clk);
    #1;
    ibus_ack = 1'b0;
  endtask

  task automatic redirect_cycle(input logic [31:0] pc, input logic ack, input logic [31:0] rdata);
    redirect    = 1'b1;
    redirect_pc = pc;
    ibus_ack    = ack;
    ibus_rdata  = rdata;
    @(posedge clk);
    sb.delete();
    #1;
    redirect = 1'b0;
    ibus_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(ibus_req), 32'd0);
    chk("rst_addr", ibus_addr, 32'hBFC0_0000);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
`ifdef IF_ADEL_EN
    chk("rst_adel", 32'(inst_adel), 32'd0);
`endif
    resetn = 1'b1;
    idle();

    // Decode stalled: exactly two words fill the buffer, then fetch stops.
    ack_cycle(32'hBFC0_0000);
    chk("first_valid", 32'(inst_valid), 32'd1);
    chk("first_pc", inst_pc, 32'hBFC0_0000);
    ack_cycle(32'hBFC0_0004);
    for (int i = 0; i < 3; i++) begin
      chk("full_req", 32'(ibus_req), 32'd0);
      chk("hold_inst", inst, 32'hADF4_5678);
      chk("hold_pc", inst_pc, 32'hBFC0_0000);
      idle();
    end

    // Streaming with continuous acks.
    id_ready = 1'b1;
    idle();
    ack_cycle(32'hBFC0_0008);
    ack_cycle(32'hBFC0_000C);
    ack_cycle(32'hBFC0_0010);
    idle();
    chk("drain_valid", 32'(inst_valid), 32'd0);

    // Redirect while a request is outstanding; late response is dropped.
    redirect_cycle(32'h8000_0180, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      chk("disc_req", 32'(ibus_req), 32'd1);
      chk("disc_addr", ibus_addr, 32'hBFC0_0014);
      chk("disc_valid", 32'(inst_valid), 32'd0);
      idle();
    end
    ibus_ack   = 1'b1;
    ibus_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    ibus_ack = 1'b0;
    chk("disc_drop_valid", 32'(inst_valid), 32'd0);
    ack_cycle(32'h8000_0180);
    ack_cycle(32'h8000_0184);

    // Redirect coincident with ack.
    redirect_cycle(32'h0000_1000, 1'b1, 32'hCAFE_F00D);
    chk("coinc_req", 32'(ibus_req), 32'd1);
    chk("coinc_addr", ibus_addr, 32'h0000_1000);
    chk("coinc_valid", 32'(inst_valid), 32'd0);
    ack_cycle(32'h0000_1000);

    // PC wrap at the top of the address space.
    redirect_cycle(32'hFFFF_FFFC, 1'b1, 32'h0BAD_0BAD);
    ack_cycle(32'hFFFF_FFFC);
    chk("wrap_pc0", inst_pc, 32'hFFFF_FFFC);
    ack_cycle(32'h0000_0000);
    chk("wrap_pc1", inst_pc, 32'h0000_0000);

    // Misaligned redirect.
    id_ready = 1'b0;
    redirect_cycle(32'h8000_0002, 1'b1, 32'h0BAD_0BAD);
`ifdef IF_ADEL_EN
    chk("adel_req", 32'(ibus_req), 32'd0);
    chk("adel_valid", 32'(inst_valid), 32'd1);
    chk("adel_flag", 32'(inst_adel), 32'd1);
    chk("adel_pc", inst_pc, 32'h8000_0002);
    chk("adel_inst", inst, 32'h0);
    idle();
    idle();
    chk("adel_idle_req", 32'(ibus_req), 32'd0);
    sb.push_back({32'h0, 32'h8000_0002});
    id_ready = 1'b1;
    idle();
    chk("adel_idle_req2", 32'(ibus_req), 32'd0);
    redirect_cycle(32'h8000_0000, 1'b0, 32'h0);
`endif
    chk("align_req", 32'(ibus_req), 32'd1);
    chk("align_addr", ibus_addr, 32'h8000_0000);
    chk("align_valid", 32'(inst_valid), 32'd0);
    id_ready = 1'b1;

    // Asynchronous reset mid-stream, with a late ack during reset.
    ack_cycle(32'h8000_0000);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_req", 32'(ibus_req), 32'd0);
    chk("arst_addr", ibus_addr, 32'hBFC0_0000);
    chk("arst_valid", 32'(inst_valid), 32'd0);
    sb.delete();
    ibus_ack   = 1'b1;
    ibus_rdata = 32'h1111_1111;
    @(posedge clk);
    #1;
    ibus_ack = 1'b0;
    resetn   = 1'b1;
    idle();
    chk("rerun_req", 32'(ibus_req), 32'd1);
    chk("rerun_valid", 32'(inst_valid), 32'd0);
    ack_cycle(32'hBFC0_0000);
    idle();
    chk("sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
